// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : In-flight producer tracker selecting the youngest forwardable
//               source per operand, stalling issue on not-yet-ready results.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3,
  parameter int ALU_READY  = 1,
  parameter int MEM_READY  = 2,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  writeback_en,
  input  logic                  writeback_from_mem,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue_fire,
  output logic [SEL_W-1:0]      rs1_fwd_sel,
  output logic [SEL_W-1:0]      rs2_fwd_sel,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb_en;
    logic                  from_mem;
  } entry_t;

  entry_t            r_pipe [1:STAGES];
  logic [CNT_W-1:0]  r_stall_count;

  logic [STAGES:1]   w_ready;
  logic [STAGES:1]   w_match1;
  logic [STAGES:1]   w_match2;
  logic              w_hz1;
  logic              w_hz2;
  logic [SEL_W-1:0]  w_sel1;
  logic [SEL_W-1:0]  w_sel2;
  logic              w_stall;
  logic              w_fire;

  // Per-stage readiness is fixed by stage position and producer kind.
  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    assign w_ready[k]  = r_pipe[k].from_mem ? (k >= MEM_READY) : (k >= ALU_READY);
    assign w_match1[k] = use_rs1 && r_pipe[k].valid && r_pipe[k].wb_en &&
                         (r_pipe[k].rd == rs1_addr) && (rs1_addr != '0);
    assign w_match2[k] = use_rs2 && r_pipe[k].valid && r_pipe[k].wb_en &&
                         (r_pipe[k].rd == rs2_addr) && (rs2_addr != '0);
  end

  // Scan oldest to youngest so the lowest matching stage overrides.
  always_comb begin
    w_hz1  = 1'b0;
    w_hz2  = 1'b0;
    w_sel1 = '0;
    w_sel2 = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (w_match1[k]) begin
        w_sel1 = w_ready[k] ? SEL_W'(k) : '0;
        w_hz1  = ~w_ready[k];
      end
      if (w_match2[k]) begin
        w_sel2 = w_ready[k] ? SEL_W'(k) : '0;
        w_hz2  = ~w_ready[k];
      end
    end
  end

  assign w_stall     = issue_valid & ~flush & (w_hz1 | w_hz2);
  assign w_fire      = issue_valid & ~w_stall & ~flush;
  assign stall       = w_stall;
  assign issue_fire  = w_fire;
  assign rs1_fwd_sel = w_sel1;
  assign rs2_fwd_sel = w_sel2;
  assign stall_count = r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= STAGES; k++) begin
        r_pipe[k] <= '0;
      end
      r_stall_count <= '0;
    end else begin
      r_pipe[1] <= w_fire ? entry_t'{valid: 1'b1, rd: rd_addr, wb_en: writeback_en,
                                     from_mem: writeback_from_mem}
                          : entry_t'('0);
      // A flush kills the stage-1 entry before it can advance.
      r_pipe[2] <= flush ? entry_t'('0) : r_pipe[1];
      for (int k = 3; k <= STAGES; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
      if (w_stall && !(&r_stall_count)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard (default
//               and STAGES=5/MEM_READY=4/CNT_W=2 configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic       use_rs1, use_rs2, writeback_en, writeback_from_mem, flush;

  logic        a_stall, a_fire;
  logic [1:0]  a_sel1, a_sel2;
  logic [31:0] a_cnt;
  logic        b_stall, b_fire;
  logic [2:0]  b_sel1, b_sel2;
  logic [1:0]  b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_a (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd_addr(rd_addr), .writeback_en(writeback_en), .writeback_from_mem(writeback_from_mem),
    .flush(flush), .stall(a_stall), .issue_fire(a_fire),
    .rs1_fwd_sel(a_sel1), .rs2_fwd_sel(a_sel2), .stall_count(a_cnt)
  );

  hazard_scoreboard #(.STAGES(5), .ALU_READY(1), .MEM_READY(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd_addr(rd_addr), .writeback_en(writeback_en), .writeback_from_mem(writeback_from_mem),
    .flush(flush), .stall(b_stall), .issue_fire(b_fire),
    .rs1_fwd_sel(b_sel1), .rs2_fwd_sel(b_sel2), .stall_count(b_cnt)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // iv, rs1, rs2, use1, use2, rd, wb, mem, flush; settles 1ns before returning
  task automatic drive(input logic iv, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2, input logic [4:0] d,
                       input logic wb, input logic mem, input logic fl);
    issue_valid = iv; rs1_addr = s1; rs2_addr = s2; use_rs1 = u1; use_rs2 = u2;
    rd_addr = d; writeback_en = wb; writeback_from_mem = mem; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_value("rst_stall", a_stall, 0);
    check_value("rst_sel1", a_sel1, 0);
    check_value("rst_sel2", a_sel2, 0);
    check_value("rst_cnt", a_cnt, 0);
    check_value("rst_fire", a_fire, 1);
    check_value("rst_cnt_b", b_cnt, 0);
    tick();

    // addi x5 then add x6,x5,x5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    check_value("addi_fire", a_fire, 1);
    tick();
    drive(1, 5, 5, 1, 1, 6, 1, 0, 0);
    check_value("alu_fwd_stall", a_stall, 0);
    check_value("alu_fwd_sel1", a_sel1, 1);
    check_value("alu_fwd_sel2", a_sel2, 1);
    tick();

    // lw x7 then add x8,x7,x0
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 7, 0, 1, 1, 8, 1, 0, 0);
    check_value("ld_use_stall", a_stall, 1);
    check_value("ld_use_fire", a_fire, 0);
    check_value("ld_use_sel1", a_sel1, 0);
    tick();
    check_value("ld_use_cnt", a_cnt, 1);
    check_value("ld_fwd_stall", a_stall, 0);
    check_value("ld_fwd_sel1", a_sel1, 2);
    check_value("ld_fwd_sel2", a_sel2, 0);
    check_value("ld_fwd_fire", a_fire, 1);
    tick();

    // x9 at stages 1 and 3
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0);  tick();
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0);  tick();
    drive(1, 9, 9, 1, 0, 0, 0, 0, 0);
    check_value("youngest_sel1", a_sel1, 1);
    check_value("unused_sel2", a_sel2, 0);
    drive(1, 9, 9, 0, 1, 0, 0, 0, 0);
    check_value("unused_sel1", a_sel1, 0);
    check_value("youngest_sel2", a_sel2, 1);
    tick();

    // lw x4, then flush with a dependent in ID, then read x4
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0); tick();
    drive(1, 4, 0, 1, 0, 15, 1, 0, 1);
    check_value("flush_stall", a_stall, 0);
    check_value("flush_fire", a_fire, 0);
    tick();
    drive(1, 4, 4, 1, 1, 0, 0, 0, 0);
    check_value("post_flush_stall", a_stall, 0);
    check_value("post_flush_sel1", a_sel1, 0);
    check_value("post_flush_sel2", a_sel2, 0);
    check_value("post_flush_cnt", a_cnt, 1);
    tick();

    // load writing x0, then read x0
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
    check_value("x0_stall", a_stall, 0);
    check_value("x0_sel1", a_sel1, 0);
    check_value("x0_sel2", a_sel2, 0);
    tick();

    // three x11 producers in flight, then reset
    drive(1, 0, 0, 0, 0, 11, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 11, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 11, 1, 1, 0); tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0;
    drive(1, 11, 11, 1, 1, 0, 0, 0, 0);
    check_value("mid_rst_stall", a_stall, 0);
    check_value("mid_rst_sel1", a_sel1, 0);
    check_value("mid_rst_sel2", a_sel2, 0);
    check_value("mid_rst_cnt", a_cnt, 0);
    tick();

    // Deep pipe: lw x3 then dependent, three stalls then sel=4
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0); tick();
    drive(1, 3, 0, 1, 0, 13, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check_value($sformatf("deep_stall%0d", i), b_stall, 1);
      check_value($sformatf("deep_cnt%0d", i), b_cnt, i);
      tick();
    end
    check_value("deep_release_stall", b_stall, 0);
    check_value("deep_release_sel1", b_sel1, 4);
    check_value("deep_release_fire", b_fire, 1);
    check_value("deep_release_cnt", b_cnt, 3);
    tick();

    // Second load-use chain: counter must hold at all-ones
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0); tick();
    drive(1, 12, 0, 1, 0, 14, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check_value($sformatf("sat_stall%0d", i), b_stall, 1);
      check_value($sformatf("sat_cnt%0d", i), b_cnt, 3);
      tick();
    end
    check_value("sat_release_sel1", b_sel1, 4);
    check_value("sat_release_cnt", b_cnt, 3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
